// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: MIPS opcode constants, hazard FSM state encoding
// and the "does this opcode read rt" decode used by load-use detection.
package pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LOADUSE  = 2'd1,
    HZ_FLUSH    = 2'd2,
    HZ_FREEZE   = 2'd3
  } hz_state_t;

  // lw writes rt rather than reading it, so it never depends on rt.
  function automatic logic uses_rt(input logic [5:0] op);
    logic r;
    case (op)
      OP_RTYPE, OP_BEQ, OP_SW: r = 1'b1;
      OP_LW:                   r = 1'b0;
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hz_sat_counter.sv
// Saturating event counter with asynchronous active-high reset; counts one per
// cycle while inc is high and sticks at all-ones.
module hz_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage MIPS hazard controller: load-use stalls, MEM-resolved branch flushes
// and data-memory freezes. Event counters are built only with HAZARD_STATS_EN.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             pc_take_branch,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic             pipe_hold,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  hz_state_t state_q, state_d;
  logic      flush_pend_q, flush_pend_d;
  logic      lu;

  assign lu = id_valid && ex_memread && (ex_rt != 5'd0) &&
              ((ex_rt == id_rs) || (uses_rt(id_opcode) && (ex_rt == id_rt)));

  assign state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= HZ_RUN;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Strobes are Mealy: the stage registers act on them at the next edge.
  always_comb begin
    pc_write       = 1'b1;
    pc_take_branch = 1'b0;
    ifid_write     = 1'b1;
    ifid_flush     = 1'b0;
    idex_bubble    = 1'b0;
    exmem_flush    = 1'b0;
    pipe_hold      = 1'b0;
    state_d        = state_q;
    flush_pend_d   = flush_pend_q;

    case (state_q)
      HZ_RUN, HZ_LOADUSE, HZ_FLUSH: begin
        if (mem_busy) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          pipe_hold  = 1'b1;
          if (mem_branch_taken) flush_pend_d = 1'b1;
          state_d    = HZ_FREEZE;
        end else if (mem_branch_taken && (state_q != HZ_FLUSH)) begin
          pc_take_branch = 1'b1;
          ifid_flush     = 1'b1;
          idex_bubble    = 1'b1;
          exmem_flush    = 1'b1;
          state_d        = HZ_FLUSH;
        end else if (lu && (state_q == HZ_RUN)) begin
          // lu is masked right after a stall or a flush
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          state_d     = HZ_LOADUSE;
        end else begin
          state_d = HZ_RUN;
        end
      end
      HZ_FREEZE: begin
        if (mem_busy) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          pipe_hold    = 1'b1;
          flush_pend_d = flush_pend_q | mem_branch_taken;
        end else if (flush_pend_q || mem_branch_taken) begin
          pc_take_branch = 1'b1;
          ifid_flush     = 1'b1;
          idex_bubble    = 1'b1;
          exmem_flush    = 1'b1;
          flush_pend_d   = 1'b0;
          state_d        = HZ_FLUSH;
        end else if (lu) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          state_d     = HZ_LOADUSE;
        end else begin
          state_d = HZ_RUN;
        end
      end
      default: state_d = HZ_RUN;
    endcase

    if (reset) begin
      pc_write       = 1'b0;
      pc_take_branch = 1'b0;
      ifid_write     = 1'b0;
      ifid_flush     = 1'b0;
      idex_bubble    = 1'b0;
      exmem_flush    = 1'b0;
      pipe_hold      = 1'b0;
    end
  end

`ifdef HAZARD_STATS_EN
  logic stall_ev, flush_ev, hold_ev;

  // A flush also raises idex_bubble; only a bubble without a flush is a stall.
  assign stall_ev = idex_bubble & ~ifid_flush;
  assign flush_ev = ifid_flush;
  assign hold_ev  = pipe_hold;

  hz_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(stall_ev), .count(stall_cnt)
  );
  hz_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .reset(reset), .inc(flush_ev), .count(flush_cnt)
  );
  hz_sat_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
    .clk(clk), .reset(reset), .inc(hold_ev), .count(freeze_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign flush_cnt  = '0;
  assign freeze_cnt = '0;
`endif

endmodule
